// File: rtl/drv_cfg_apply.sv
// drv_cfg_apply: applies staged delay codes and current-leg enables to the
// LVDS driver macro. Delay codes are committed on a serializer frame boundary
// (or forced after a timeout); current legs ramp one bit at a time.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | nothing in flight, waiting for a commit request
// S_ARMED | targets staged, waiting for frame sync or sync timeout
// S_RAMP  | delays applied, stepping o_current toward the staged target
module drv_cfg_apply #(
  parameter int unsigned RAMP_DIV     = 4,
  parameter int unsigned SYNC_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_del_sync,
  input  logic [15:0] i_del_p,
  input  logic [15:0] i_del_n,
  input  logic [31:0] i_current,
  input  logic        i_update_req,
  input  logic        i_frame_sync,
  output logic [15:0] o_del_sync,
  output logic [15:0] o_del_sync_inv,
  output logic [15:0] o_del_p,
  output logic [15:0] o_del_p_inv,
  output logic [15:0] o_del_n,
  output logic [15:0] o_del_n_inv,
  output logic [31:0] o_current,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_sync_timeout
);

  localparam int          RW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [15:0] TMO_LAST  = 16'(SYNC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RAMP  = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   stg_del_sync;
  logic [15:0]   stg_del_p;
  logic [15:0]   stg_del_n;
  logic [31:0]   stg_current;
  logic          pending;
  logic [15:0]   tmo_cnt;
  logic [RW-1:0] ramp_cnt;

  logic          tmo_hit;
  logic [31:0]   cur_diff;
  logic [31:0]   cur_step;

  // Inverted delay codes track the applied registers in the same cycle.
  assign o_del_sync_inv = ~o_del_sync;
  assign o_del_p_inv    = ~o_del_p;
  assign o_del_n_inv    = ~o_del_n;

  // A zero timeout parameter disables the forced apply entirely.
  assign tmo_hit = (SYNC_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  // Isolate the lowest-index differing leg so each step moves one bit only.
  assign cur_diff = o_current ^ stg_current;
  assign cur_step = cur_diff & (~cur_diff + 32'd1);

  // Sequencer: staging, frame-aligned delay apply and current-leg ramp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      stg_del_sync   <= '0;
      stg_del_p      <= '0;
      stg_del_n      <= '0;
      stg_current    <= '0;
      pending        <= 1'b0;
      tmo_cnt        <= '0;
      ramp_cnt       <= '0;
      o_del_sync     <= '0;
      o_del_p        <= '0;
      o_del_n        <= '0;
      o_current      <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_sync_timeout <= 1'b0;
    end else begin
      o_done         <= 1'b0;
      o_sync_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_update_req) begin
            stg_del_sync <= i_del_sync;
            stg_del_p    <= i_del_p;
            stg_del_n    <= i_del_n;
            stg_current  <= i_current;
            tmo_cnt      <= '0;
            state        <= S_ARMED;
            o_busy       <= 1'b1;
          end
        end

        S_ARMED: begin
          if (i_frame_sync || tmo_hit) begin
            // A request arriving with the apply is deferred: the values
            // already staged go out now, the new ones follow after the ramp.
            o_del_sync     <= stg_del_sync;
            o_del_p        <= stg_del_p;
            o_del_n        <= stg_del_n;
            ramp_cnt       <= '0;
            state          <= S_RAMP;
            o_sync_timeout <= ~i_frame_sync;
            if (i_update_req) pending <= 1'b1;
          end else if (i_update_req) begin
            stg_del_sync <= i_del_sync;
            stg_del_p    <= i_del_p;
            stg_del_n    <= i_del_n;
            stg_current  <= i_current;
            tmo_cnt      <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_RAMP: begin
          if (cur_diff == '0) begin
            o_done <= 1'b1;
            // A request landing on the completion cycle is treated as
            // pending so it is not lost.
            if (pending || i_update_req) begin
              pending      <= 1'b0;
              stg_del_sync <= i_del_sync;
              stg_del_p    <= i_del_p;
              stg_del_n    <= i_del_n;
              stg_current  <= i_current;
              tmo_cnt      <= '0;
              state        <= S_ARMED;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            if (i_update_req) pending <= 1'b1;
            if (ramp_cnt == RAMP_LAST) begin
              o_current <= o_current ^ cur_step;
              ramp_cnt  <= '0;
            end else begin
              ramp_cnt <= ramp_cnt + 1'b1;
            end
          end
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drv_cfg_apply.sv
// Directed bench for drv_cfg_apply: one instance with RAMP_DIV=4 and
// SYNC_TIMEOUT=16 for the main sequence, one with SYNC_TIMEOUT=0.
module tb_drv_cfg_apply;

  logic        clk;
  logic        reset;
  logic [15:0] del_sync, del_p, del_n;
  logic [31:0] current;
  logic        upd, fs, req0, fs0;

  logic [15:0] o_del_sync, o_del_sync_inv, o_del_p, o_del_p_inv, o_del_n, o_del_n_inv;
  logic [31:0] o_current;
  logic        o_busy, o_done, o_tmo;

  logic [15:0] z_del_sync, z_del_sync_inv, z_del_p, z_del_p_inv, z_del_n, z_del_n_inv;
  logic [31:0] z_current;
  logic        z_busy, z_done, z_tmo;

  int n_cmp = 0;
  int n_err = 0;

  drv_cfg_apply #(.RAMP_DIV(4), .SYNC_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_del_sync(del_sync), .i_del_p(del_p), .i_del_n(del_n),
    .i_current(current), .i_update_req(upd), .i_frame_sync(fs),
    .o_del_sync(o_del_sync), .o_del_sync_inv(o_del_sync_inv),
    .o_del_p(o_del_p), .o_del_p_inv(o_del_p_inv),
    .o_del_n(o_del_n), .o_del_n_inv(o_del_n_inv),
    .o_current(o_current), .o_busy(o_busy), .o_done(o_done),
    .o_sync_timeout(o_tmo)
  );

  drv_cfg_apply #(.RAMP_DIV(4), .SYNC_TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_del_sync(del_sync), .i_del_p(del_p), .i_del_n(del_n),
    .i_current(current), .i_update_req(req0), .i_frame_sync(fs0),
    .o_del_sync(z_del_sync), .o_del_sync_inv(z_del_sync_inv),
    .o_del_p(z_del_p), .o_del_p_inv(z_del_p_inv),
    .o_del_n(z_del_n), .o_del_n_inv(z_del_n_inv),
    .o_current(z_current), .o_busy(z_busy), .o_done(z_done),
    .o_sync_timeout(z_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0; del_sync = '0; del_p = '0; del_n = '0; current = '0;
    upd = 1'b0; fs = 1'b0; req0 = 1'b0; fs0 = 1'b0;
    #2;
    chk("rst_del_sync", o_del_sync, 32'h0000);
    chk("rst_del_sync_inv", o_del_sync_inv, 32'hFFFF);
    chk("rst_del_p_inv", o_del_p_inv, 32'hFFFF);
    chk("rst_current", o_current, 32'h0);
    chk("rst_busy", o_busy, 32'h0);
    chk("rst_done", o_done, 32'h0);
    chk("rst_tmo", o_tmo, 32'h0);
    #10 reset = 1'b1;
    tick(1);

    // basic apply, sync three cycles after the request
    del_sync = 16'h00FF; del_p = 16'h0011; del_n = 16'h0022; current = 32'h7;
    upd = 1'b1; tick(1); upd = 1'b0;
    chk("basic_busy", o_busy, 32'h1);
    chk("basic_del_hold", o_del_sync, 32'h0000);
    tick(2);
    fs = 1'b1; tick(1); fs = 1'b0;
    chk("basic_del_sync", o_del_sync, 32'h00FF);
    chk("basic_del_sync_inv", o_del_sync_inv, 32'hFF00);
    chk("basic_del_p", o_del_p, 32'h0011);
    chk("basic_cur_m0", o_current, 32'h0);
    tick(3); chk("basic_cur_m3", o_current, 32'h0);
    tick(1); chk("basic_cur_m4", o_current, 32'h1);
    tick(3); chk("basic_cur_m7", o_current, 32'h1);
    tick(1); chk("basic_cur_m8", o_current, 32'h3);
    tick(4); chk("basic_cur_m12", o_current, 32'h7);
    chk("basic_done_early", o_done, 32'h0);
    tick(1);
    chk("basic_done", o_done, 32'h1);
    chk("basic_busy_low", o_busy, 32'h0);
    tick(1); chk("basic_done_once", o_done, 32'h0);

    // decrement 7 -> 6 -> 4
    current = 32'h4;
    upd = 1'b1; tick(1); upd = 1'b0;
    fs = 1'b1; tick(1); fs = 1'b0;
    tick(4); chk("dec_step1", o_current, 32'h6);
    tick(4); chk("dec_step2", o_current, 32'h4);
    chk("dec_done_early", o_done, 32'h0);
    tick(1); chk("dec_done", o_done, 32'h1);

    // latest request in ARMED wins
    del_p = 16'h0001; upd = 1'b1; tick(1);
    del_p = 16'h0002; tick(1); upd = 1'b0;
    fs = 1'b1; tick(1); fs = 1'b0;
    chk("rearm_del_p", o_del_p, 32'h0002);
    chk("rearm_del_p_inv", o_del_p_inv, 32'hFFFD);
    tick(1); chk("rearm_done_k0", o_done, 32'h1);

    // forced apply after 16 cycles without frame sync
    del_n = 16'h5A5A;
    upd = 1'b1; tick(1); upd = 1'b0;
    tick(15);
    chk("tmo_del_hold", o_del_n, 32'h0022);
    chk("tmo_pulse_early", o_tmo, 32'h0);
    chk("tmo_busy", o_busy, 32'h1);
    tick(1);
    chk("tmo_del_n", o_del_n, 32'h5A5A);
    chk("tmo_del_n_inv", o_del_n_inv, 32'hA5A5);
    chk("tmo_pulse", o_tmo, 32'h1);
    tick(1);
    chk("tmo_pulse_once", o_tmo, 32'h0);
    chk("tmo_done", o_done, 32'h1);

    // request during RAMP is deferred to the next frame sync
    current = 32'hC; del_sync = 16'h1234;
    upd = 1'b1; tick(1); upd = 1'b0;
    fs = 1'b1; tick(1); fs = 1'b0;
    chk("rr_del_first", o_del_sync, 32'h1234);
    del_sync = 16'hABCD; current = 32'h8;
    upd = 1'b1; tick(1); upd = 1'b0;
    tick(3);
    chk("rr_cur_first", o_current, 32'hC);
    chk("rr_done_early", o_done, 32'h0);
    tick(1);
    chk("rr_done", o_done, 32'h1);
    chk("rr_busy_stays", o_busy, 32'h1);
    chk("rr_del_hold", o_del_sync, 32'h1234);
    tick(3);
    chk("rr_del_wait", o_del_sync, 32'h1234);
    fs = 1'b1; tick(1); fs = 1'b0;
    chk("rr_del_second", o_del_sync, 32'hABCD);
    tick(4); chk("rr_cur_second", o_current, 32'h8);
    tick(1); chk("rr_done_second", o_done, 32'h1);

    // timeout disabled: never applies without frame sync
    req0 = 1'b1; tick(1); req0 = 1'b0;
    chk("notmo_busy", z_busy, 32'h1);
    tick(2000);
    chk("notmo_del_p", z_del_p, 32'h0000);
    chk("notmo_del_sync_inv", z_del_sync_inv, 32'hFFFF);
    chk("notmo_still_busy", z_busy, 32'h1);

    // asynchronous reset mid-ramp at o_current = 3
    reset = 1'b0; tick(1); reset = 1'b1; tick(1);
    current = 32'hF;
    upd = 1'b1; tick(1); upd = 1'b0;
    fs = 1'b1; tick(1); fs = 1'b0;
    chk("mid_del_p", o_del_p, 32'h0002);
    tick(8);
    chk("mid_cur", o_current, 32'h3);
    chk("mid_busy", o_busy, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_current", o_current, 32'h0);
    chk("arst_del_p", o_del_p, 32'h0000);
    chk("arst_del_p_inv", o_del_p_inv, 32'hFFFF);
    chk("arst_busy", o_busy, 32'h0);
    #10 reset = 1'b1;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/drv_cfg_apply.md
# drv_cfg_apply

Downstream stage of the Wishbone driver-configuration register block. It takes the register-file outputs (delay codes and current-leg enables) and applies them to the LVDS driver macro safely. Delay codes are committed only on a serializer frame boundary. The 32 current-leg enables are changed one bit at a time at a programmable rate, which limits supply transients in the output stage.

## Interface
Parameters:
- RAMP_DIV, 4: cycles between current-leg steps; must be ≥1.
- SYNC_TIMEOUT, 1024: cycles waited in ARMED for i_frame_sync before forcing the apply; 0 disables the timeout. 16-bit counter.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- i_del_sync  in  16  target sync-path delay code, from the config register block.
- i_del_p  in  16  target P-path delay code.
- i_del_n  in  16  target N-path delay code.
- i_current  in  32  target current-leg enable vector.
- i_update_req  in  1  single-cycle commit request.
- i_frame_sync  in  1  single-cycle frame-boundary strobe from the serializer.
- o_del_sync / o_del_sync_inv  out  16 each  applied sync delay and its bitwise inverse.
- o_del_p / o_del_p_inv  out  16 each  applied P delay and its inverse.
- o_del_n / o_del_n_inv  out  16 each  applied N delay and its inverse.
- o_current  out  32  applied current-leg enables.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_done  out  1  one-cycle pulse when an update completes.
- o_sync_timeout  out  1  one-cycle pulse when an apply was forced by timeout.

## Operation
- Staging registers stg_* hold the target values. The applied registers are o_del_*, o_current and a 1-bit pending flag.
- *_inv outputs are the combinational inverse of the registered o_del_*. They always change in the same cycle as o_del_*.
- FSM states:
  - IDLE: on i_update_req, latch all i_* into stg_*, clear the timeout counter, go to ARMED.
  - ARMED: on i_update_req, re-latch stg_* and restart the timeout counter (latest request wins).
    - If i_frame_sync is high, load o_del_* from stg_del_*, clear the ramp counter and go to RAMP.
    - If SYNC_TIMEOUT ≠ 0 and the counter equals SYNC_TIMEOUT-1, perform the same apply and pulse o_sync_timeout.
    - If i_frame_sync and i_update_req arrive together, apply the previously staged values and set pending.
  - RAMP: each cycle, compare o_current with stg_current.
    - If equal: go to IDLE and pulse o_done. If pending is set, instead clear it, latch i_* into stg_*, go to ARMED and still pulse o_done.
    - If not equal: increment the ramp counter. When it reaches RAMP_DIV-1, toggle the lowest-index bit where o_current differs from stg_current, then clear the counter.
    - i_update_req sets pending.
- i_frame_sync is ignored outside ARMED.
- Delay codes never change outside the ARMED→RAMP transition.

## Timing
- Reset values:
  - o_del_* = 16'h0000, o_del_*_inv = 16'hFFFF.
  - o_current = 0, o_busy = 0, o_done = 0, o_sync_timeout = 0.
  - State IDLE; stg_*, counters and pending cleared.
- Reset takes effect immediately, including mid-ramp.
- i_update_req sampled at edge N: o_busy is high after edge N.
- i_frame_sync sampled at edge M in ARMED: new o_del_* and *_inv are visible after edge M; state is RAMP.
- Ramp with k differing bits: steps occur at edges M+RAMP_DIV·j for j = 1..k. o_done is high for exactly the cycle after edge M+k·RAMP_DIV+1, and o_busy drops at the same edge.
- k = 0: o_done follows at edge M+1.
- Timeout: forced apply at the edge where the counter reaches SYNC_TIMEOUT-1, i.e. SYNC_TIMEOUT cycles after entering or re-arming ARMED. o_sync_timeout pulses in the same cycle that the delays update.
- o_current changes by exactly one bit per step, never more.

## Test plan
- **Reset:** assert reset asynchronously mid-RAMP with o_current=32'h3 → all outputs return to the reset values immediately, including o_del_p_inv=16'hFFFF and o_busy=0.
- **Basic apply (RAMP_DIV=4):** i_del_sync=16'h00FF, i_current=32'h7; req, then frame_sync 3 cycles later → o_del_sync=16'h00FF and o_del_sync_inv=16'hFF00 one edge after sync. o_current steps 1→3→7 at 4-cycle spacing, followed by a single o_done pulse.
- **Decrement:** from o_current=32'h7, target 32'h4 → 32'h6, then 32'h4; o_done one cycle after the last step.
- **Timeout (SYNC_TIMEOUT=16):** req, no frame_sync → delays apply 16 cycles after arming, with an o_sync_timeout pulse. With SYNC_TIMEOUT=0 there is no apply after 2000 cycles.
- **Re-request in ARMED:** req with del_p=16'h1, then req with del_p=16'h2 before sync → o_del_p=16'h2 after sync.
- **Re-request in RAMP:** req during RAMP → o_done pulses, o_busy stays high, FSM returns to ARMED, and the second set applies on the next frame_sync.
